mux8_rr_scheduler: RTL and testbench



---
 rtl/mux8_sched_pkg.sv | 14 +
 rtl/rr_pick8.sv | 31 +++
 rtl/mux8_rr_scheduler.sv | 109 ++++++++++
 tb/tb_mux8_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_sched_pkg.sv
// Shared constants and state encoding for the 8-way round-robin mux scheduler.
package mux8_sched_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request at or after ptr, wrapping 7 -> 0.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     idx;

    // Rotate right by ptr so the search origin lands on bit 0.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
    end

    // Priority encode the rotated vector (lowest bit wins), then undo the rotation.
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
        pick = idx + ptr;
        any  = |req;
    end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for a shared 8:1 mux: bounded bursts, guard gap
// after every release, select only moves on the IDLE -> GRANT edge.
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int BURST_MAX  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic               busy
);

    state_t             state, state_d;
    logic [SEL_W-1:0]   ptr, ptr_d;
    logic [CNT_W-1:0]   burst_cnt, burst_d;
    logic [1:0]         gap_cnt, gap_d;
    logic [SEL_W-1:0]   sel_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               gnt_valid_d, busy_d;

    logic [SEL_W-1:0]   pick;
    logic               any;
    logic               release_now;
    logic               start_grant;

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // Release conditions for the active grant; all three collapse into one release.
    always_comb begin
        release_now = done || !req[sel] || (burst_cnt == CNT_W'(BURST_MAX));
        start_grant = (state == IDLE) && any;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (any)          state_d = GRANT;
            GRANT:   if (release_now)  state_d = GAP;
            GAP:     if (gap_cnt <= 2'd1) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Next values for counters and the registered outputs.
    always_comb begin
        ptr_d       = ptr;
        burst_d     = burst_cnt;
        gap_d       = gap_cnt;
        sel_d       = sel;
        gnt_d       = '0;
        gnt_valid_d = (state_d == GRANT);
        busy_d      = (state_d != IDLE);
        if (start_grant) begin
            ptr_d   = pick + SEL_W'(1);
            burst_d = CNT_W'(1);
            sel_d   = pick;
            gnt_d   = NUM_REQ'(1) << pick;
        end else if (state == GRANT) begin
            if (release_now) begin
                gap_d = 2'(GAP_CYCLES);
            end else begin
                gnt_d   = gnt;
                burst_d = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
            end
        end else if (state == GAP) begin
            gap_d = gap_cnt - 2'd1;
        end
    end

    // Counters and output registers; reset clears the grant without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            sel       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ptr       <= ptr_d;
            burst_cnt <= burst_d;
            gap_cnt   <= gap_d;
            sel       <= sel_d;
            gnt       <= gnt_d;
            gnt_valid <= gnt_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: abstract owner/quiet-time model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mux8_rr_scheduler;

    localparam int BURST_MAX  = 4;
    localparam int GAP_CYCLES = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       busy;

    int npass  = 0;
    int ntotal = 0;

    mux8_rr_scheduler #(.BURST_MAX(BURST_MAX), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: who owns the mux, how long they've held it, how many quiet cycles
    // remain before arbitration may happen, and where the next search starts.
    typedef struct {
        int owner;
        int held;
        int quiet;
        int rr;
        int sel;
    } mstate_t;

    mstate_t m = '{owner: -1, held: 0, quiet: 0, rr: 0, sel: 0};

    function automatic mstate_t model_step(mstate_t s, logic [7:0] r, logic d);
        mstate_t n;
        int c;
        n = s;
        if (s.owner >= 0) begin
            if (d || !r[s.owner] || s.held == BURST_MAX) begin
                n.owner = -1;
                n.quiet = GAP_CYCLES;
            end else if (s.held < 15) begin
                n.held = s.held + 1;
            end
        end else if (s.quiet > 0) begin
            n.quiet = s.quiet - 1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                c = (s.rr + k) % 8;
                if (r[c] && n.owner < 0) begin
                    n.owner = c;
                    n.held  = 1;
                    n.sel   = c;
                    n.rr    = (c + 1) % 8;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, held: 0, quiet: 0, rr: 0, sel: 0};
        else        m <= model_step(m, req, done);
    end

    logic       prev_busy = 1'b0;
    logic [2:0] prev_sel  = 3'd0;

    // Per-cycle comparison against the model, plus select stability while busy.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
        end else begin
            check("gnt",       32'(gnt),       (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
            check("sel",       32'(sel),       32'(m.sel));
            check("gnt_valid", 32'(gnt_valid), 32'(m.owner >= 0));
            check("busy",      32'(busy),      32'(m.owner >= 0 || m.quiet > 0));
            if (prev_busy) check("sel_stable", 32'(sel), 32'(prev_sel));
            prev_busy <= busy;
            prev_sel  <= sel;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (!gnt_valid && n < 60) begin
            step();
            n++;
        end
        if (!gnt_valid) check("wait_grant_timeout", 32'(gnt_valid), 32'd1);
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (gnt_valid && n < 60) begin
            step();
            n++;
        end
        if (gnt_valid) check("wait_release_timeout", 32'(gnt_valid), 32'd0);
    endtask

    logic [7:0] exp_pat [12] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
                                 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        check("reset_gnt",  32'(gnt),       32'h00);
        check("reset_sel",  32'(sel),       32'd0);
        check("reset_vld",  32'(gnt_valid), 32'd0);
        check("reset_busy", 32'(busy),      32'd0);

        // Single requester: 4 granted, 1 gap, 1 idle, period 6.
        req = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("single_pattern", 32'(gnt), 32'(exp_pat[i]));
        end
        check("single_sel", 32'(sel), 32'd0);

        // All requesting, done on the second grant cycle: order 0..7,0.
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            wait_grant();
            check("ff_sel", 32'(sel), 32'(g % 8));
            check("ff_gnt", 32'(gnt), 32'd1 << (g % 8));
            step();
            check("ff_hold", 32'(gnt_valid), 32'd1);
            done = 1'b1;
            step();
            done = 1'b0;
            check("ff_release", 32'(gnt_valid), 32'd0);
        end

        // Serve 4, then 8'h21 must go 5 then 0.
        req = 8'h10;
        wait_grant();
        check("p4_sel", 32'(sel), 32'd4);
        req = 8'h21;
        step();
        check("p4_withdraw", 32'(gnt), 32'h00);
        wait_grant();
        check("p5_sel", 32'(sel), 32'd5);
        wait_release();
        wait_grant();
        check("p0_after5", 32'(sel), 32'd0);

        // Requester 3 withdraws at burst count 2.
        req = 8'h08;
        wait_release();
        wait_grant();
        check("r3_sel", 32'(sel), 32'd3);
        step();
        req = 8'h00;
        step();
        check("r3_gnt",  32'(gnt),  32'h00);
        check("r3_busy", 32'(busy), 32'd1);
        check("r3_sel_hold", 32'(sel), 32'd3);

        // Asynchronous reset while requester 6 holds the mux.
        req = 8'h40;
        wait_grant();
        check("r6_sel", 32'(sel), 32'd6);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt",  32'(gnt),       32'h00);
        check("async_sel",  32'(sel),       32'd0);
        check("async_busy", 32'(busy),      32'd0);
        check("async_vld",  32'(gnt_valid), 32'd0);
        req = 8'hC1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_sel", 32'(sel), 32'd0);
        check("post_reset_gnt", 32'(gnt), 32'h01);

        // done coincides with the burst limit: one gap, then re-grant.
        req = 8'h01;
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("lim_gap_vld",  32'(gnt_valid), 32'd0);
        check("lim_gap_busy", 32'(busy),      32'd1);
        step();
        check("lim_idle_busy", 32'(busy),      32'd0);
        check("lim_idle_vld",  32'(gnt_valid), 32'd0);
        step();
        check("lim_regrant", 32'(gnt), 32'h01);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", npass, ntotal);
        $fatal(1, "watchdog");
    end

endmodule
